// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one shift per clock, 5-bit digit codes.
// Optional macro BIN2BCD_LEADING_BLANK_EN: leading zero digits (except digit 0) read as 5'd16.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [5*DIGITS-1:0]   dig_o
);

  localparam int unsigned SCR_W = 4 * DIGITS;
  localparam int unsigned DIG_W = 5 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  // Elaboration-time parameter legality
  if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be in 4..32");
  end
  if (DIGITS * 100000 < BIN_W * 30103) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [SCR_W-1:0]   scr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIG_W-1:0]   dig_q;
  logic               valid_q;
  logic               ready_q;
  logic               busy_q;

  logic [SCR_W-1:0]   adj_c;
  logic [SCR_W-1:0]   next_scr_c;
  logic [DIG_W-1:0]   dig_next_c;
  logic               unused_adj_msb;

  // Add-3 to every nibble >= 5; nibbles never exceed 9 here so no wrap
  always_comb begin
    adj_c = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) begin
        adj_c[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      end else begin
        adj_c[4*k +: 4] = scr_q[4*k +: 4];
      end
    end
  end

  // The adjusted top bit is always shifted out as zero for legal DIGITS
  assign next_scr_c     = {adj_c[SCR_W-2:0], bin_q[BIN_W-1]};
  assign unused_adj_msb = adj_c[SCR_W-1];

  // Digit codes derived from the scratch value after the final shift
`ifdef BIN2BCD_LEADING_BLANK_EN
  always_comb begin
    logic nz;
    nz         = 1'b0;
    dig_next_c = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      nz = nz | (next_scr_c[4*k +: 4] != 4'd0);
      if (k != 0 && !nz) begin
        dig_next_c[5*k +: 5] = 5'd16;
      end else begin
        dig_next_c[5*k +: 5] = {1'b0, next_scr_c[4*k +: 4]};
      end
    end
  end
`else
  always_comb begin
    dig_next_c = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      dig_next_c[5*k +: 5] = {1'b0, next_scr_c[4*k +: 4]};
    end
  end
`endif

  // Control FSM, datapath registers and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_q   <= bin_i;
            scr_q   <= '0;
            cnt_q   <= CNT_W'(BIN_W);
            state_q <= SHIFT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          scr_q <= next_scr_c;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            dig_q   <= dig_next_c;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign dig_o   = dig_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed starts push expected digits, a monitor checks each valid pulse.
module tb_bin2bcd_seq;

  localparam int unsigned BIN_W  = 32;
  localparam int unsigned DIGITS = 10;

  logic                   clk   = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   start = 1'b0;
  logic [BIN_W-1:0]       bin   = '0;
  logic                   ready;
  logic                   busy;
  logic                   valid;
  logic [5*DIGITS-1:0]    dig;

  typedef struct {
    logic [5*DIGITS-1:0] dig;
    int                  acc;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .bin_i   (bin),
    .ready_o (ready),
    .busy_o  (busy),
    .valid_o (valid),
    .dig_o   (dig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-written BCD constant -> expected 5-bit digit codes
  function automatic logic [5*DIGITS-1:0] mk(input logic [39:0] bcd);
    logic [5*DIGITS-1:0] r;
    logic nz;
    r  = '0;
    nz = 1'b0;
    for (int k = 9; k >= 0; k--) begin
      nz = nz | (bcd[4*k +: 4] != 4'd0);
      r[5*k +: 5] = {1'b0, bcd[4*k +: 4]};
`ifdef BIN2BCD_LEADING_BLANK_EN
      if (k != 0 && !nz) r[5*k +: 5] = 5'd16;
`endif
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      check("busy_is_not_ready", 64'(busy), 64'(!ready));
      if (valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_valid: got valid=1 dig=0x%0h expected no pulse", dig);
        end else begin
          e = q.pop_front();
          check("digits", 64'(dig), 64'(e.dig));
          check("latency", 64'(cyc - e.acc), 64'(BIN_W));
          check("ready_at_valid", 64'(ready), 64'd1);
        end
      end
    end
  end

  // Present a start at the current negedge; record the accepting edge
  task automatic issue(input logic [BIN_W-1:0] b, input logic [39:0] bcd);
    exp_t e;
    check("ready_before_start", 64'(ready), 64'd1);
    start = 1'b1;
    bin   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.dig = mk(bcd);
    e.acc = cyc;
    q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    int n;
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_dig",   64'(dig),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd1234, 40'h00_0000_1234);
    wait_done(100);
    repeat (2) @(negedge clk);

    issue(32'hFFFF_FFFF, 40'h42_9496_7295);
    wait_done(100);
    repeat (2) @(negedge clk);

    issue(32'd0, 40'h00_0000_0000);
    wait_done(100);
    repeat (2) @(negedge clk);

    // Start during SHIFT must be ignored
    @(negedge clk);
    issue(32'd1234, 40'h00_0000_1234);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      check("ready_low_in_shift", 64'(ready), 64'd0);
      if (i == 10) begin
        start = 1'b1;
        bin   = 32'd999;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    wait_done(100);
    repeat (2) @(negedge clk);

    // Reset mid-conversion aborts with no result
    issue(32'd5678, 40'h00_0000_5678);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    @(negedge clk);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy",  64'(busy),  64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_dig",   64'(dig),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(ready), 64'd1);
    repeat (40) @(negedge clk);

    issue(32'd42, 40'h00_0000_0042);
    wait_done(100);
    repeat (2) @(negedge clk);

    // Back-to-back: second start lands in the first result's valid cycle
    issue(32'd7, 40'h00_0000_0007);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 100);
    if (!valid) begin
      n_vec++;
      n_bad++;
      $display("FAIL b2b_first_valid: got no valid in %0d cycles expected one", n);
    end
    issue(32'd65536, 40'h00_0006_5536);
    repeat (10) @(negedge clk);
    check("hold_prev_result", 64'(dig), 64'(mk(40'h00_0000_0007)));
    wait_done(100);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
